// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder controller: FSM state encoding and default width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// Combinational 1-bit full adder; the only arithmetic element in the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller sequencing one fa_cell, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             fa_s, fa_co;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  fa_cell u_fa_cell (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // sum/cout only move on the final SHIFT cycle so the old result stays visible mid-operation
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        s_sr_d  = {fa_s, s_sr_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          sum_d   = s_sr_d;
          cout_d  = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q here is the carry into the MSB
          ovf_d   = carry_q ^ fa_co;
`endif
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: stimulus pushes expected results, a negedge monitor checks them.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           doneCycle;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  exp_t expQ[$];
  int   checkCount = 0;
  int   passCount  = 0;
  int   cycle      = 0;

  logic [W-1:0] lastSum  = '0;
  logic         lastCout = 1'b0;
  logic         lastOvf  = 1'b0;
  int           busyRun  = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
  endtask

  // Reference: plain integer arithmetic on the operands
  function automatic exp_t refModel(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                    input logic icin, input int doneCycle);
    exp_t        e;
    int unsigned total;
    int          signedTotal;
    total        = int'(ia) + int'(ib) + int'(icin);
    signedTotal  = int'($signed(ia)) + int'($signed(ib)) + int'(icin);
    e.sum        = total[W-1:0];
    e.cout       = (total >= (1 << W));
    e.ovf        = (signedTotal > (1 << (W - 1)) - 1) || (signedTotal < -(1 << (W - 1)));
    e.doneCycle  = doneCycle;
    return e;
  endfunction

  task automatic applyStimulus(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin);
    @(negedge clk);
    a     = ia;
    b     = ib;
    cin   = icin;
    start = 1'b1;
    expQ.push_back(refModel(ia, ib, icin, cycle + 1 + W));
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom_range(0, 1));
  endtask

  task automatic waitDrain();
    int budget = 0;
    while (expQ.size() != 0 && budget < 4 * W) begin
      @(negedge clk);
      budget++;
    end
    if (expQ.size() != 0) begin
      checkOutput("drainTimeout", 64'(expQ.size()), 64'd0);
      expQ.delete();
    end
  endtask

  // Monitor: pops on done, otherwise the previous result must be held
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      lastSum  = '0;
      lastCout = 1'b0;
      lastOvf  = 1'b0;
      busyRun  = 0;
    end else begin
      if (busy) busyRun++;
      else if (busyRun != 0) begin
        checkOutput("busyLength", 64'(busyRun), 64'(W + 1));
        busyRun = 0;
      end
      if (done) begin
        if (expQ.size() == 0) checkOutput("unexpectedDone", 64'd1, 64'd0);
        else begin
          e = expQ.pop_front();
          checkOutput("doneCycle", 64'(cycle), 64'(e.doneCycle));
          checkOutput("sum", 64'(sum), 64'(e.sum));
          checkOutput("cout", 64'(cout), 64'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
          checkOutput("ovf", 64'(ovf), 64'(e.ovf));
`endif
          lastSum  = e.sum;
          lastCout = e.cout;
          lastOvf  = e.ovf;
        end
      end else begin
        checkOutput("holdSum", 64'(sum), 64'(lastSum));
        checkOutput("holdCout", 64'(cout), 64'(lastCout));
`ifdef SERIAL_ADDER_OVF_EN
        checkOutput("holdOvf", 64'(ovf), 64'(lastOvf));
`endif
      end
    end
  end

  initial begin
    int k;
    logic [W-1:0] ra, rb;
    logic         rc;

    repeat (2) @(negedge clk);
    checkOutput("resetBusy", 64'(busy), 64'd0);
    checkOutput("resetDone", 64'(done), 64'd0);
    checkOutput("resetSum", 64'(sum), 64'd0);
    checkOutput("resetCout", 64'(cout), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
    checkOutput("resetOvf", 64'(ovf), 64'd0);
`endif
    rst_n = 1'b1;

    applyStimulus(8'h0F, 8'h01, 1'b0); waitDrain();
    applyStimulus(8'hFF, 8'h01, 1'b0); waitDrain();
    applyStimulus(8'hFF, 8'hFF, 1'b1); waitDrain();
    applyStimulus(8'h7F, 8'h01, 1'b0); waitDrain();
    applyStimulus(8'h80, 8'h80, 1'b0); waitDrain();

    // start pulse on the 3rd busy cycle must be ignored
    applyStimulus(8'h02, 8'h03, 1'b0);
    repeat (2) @(negedge clk);
    a     = 8'h50;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDrain();
    repeat (5) @(negedge clk);
    checkOutput("holdAfterIgnore", 64'(sum), 64'h05);

    // Abort on the 4th SHIFT cycle
    applyStimulus(8'h33, 8'h44, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("abortBusy", 64'(busy), 64'd0);
    checkOutput("abortDone", 64'(done), 64'd0);
    checkOutput("abortSum", 64'(sum), 64'd0);
    checkOutput("abortCout", 64'(cout), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h10, 8'h20, 1'b0); waitDrain();
    @(negedge clk);
    checkOutput("postResetSum", 64'(sum), 64'h30);

    // start held high restarts every WIDTH+2 cycles
    ra = W'($urandom);
    rb = W'($urandom);
    rc = 1'($urandom_range(0, 1));
    @(negedge clk);
    a     = ra;
    b     = rb;
    cin   = rc;
    start = 1'b1;
    k     = cycle + 1;
    for (int i = 0; i < 3; i++) expQ.push_back(refModel(ra, rb, rc, k + i * (W + 2) + W));
    while (cycle < k + 2 * (W + 2)) @(negedge clk);
    start = 1'b0;
    waitDrain();

    for (int i = 0; i < 20; i++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      waitDrain();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    checkOutput("queueEmpty", 64'(expQ.size()), 64'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Controller that sequences a single 1-bit full-adder cell to add two WIDTH-bit operands bit-serially, LSB first.
- Owns operand shift registers, the carry flip-flop, the bit counter and the start/busy/done handshake.
- Result is registered and held until the next operation completes.
- Sits between a requester (test harness or upstream FSM) and the shared adder cell, trading area for WIDTH-cycle latency.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only in IDLE
- a  input  WIDTH  operand A, sampled on the accepted start edge
- b  input  WIDTH  operand B, sampled on the accepted start edge
- cin  input  1  carry-in, sampled on the accepted start edge
- busy  output  1  high while state is not IDLE
- done  output  1  one-cycle pulse when sum/cout become valid
- sum  output  WIDTH  registered result
- cout  output  1  registered carry-out

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - state=IDLE, busy=0, done=0, sum=0, cout=0.
  - Shift registers, carry flop and counter = 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge k -> load a_sr=a, b_sr=b, carry=cin, cnt=0; go to SHIFT.
  - start=0 -> stay in IDLE.
- SHIFT, each cycle:
  - Drive fa_cell with (a_sr[0], b_sr[0], carry).
  - Shift a_sr and b_sr right by one.
  - Shift the cell sum bit into s_sr at the MSB.
  - carry <= cell carry; cnt++.
  - When cnt==WIDTH-1: sum <= final s_sr value including this bit; cout <= cell carry; go to DONE.
- DONE: done=1 for exactly this cycle; next state is IDLE unconditionally.
- Latency:
  - busy is high for edges k+1 .. k+WIDTH+1, i.e. WIDTH SHIFT cycles plus 1 DONE cycle.
  - done is high in the cycle after edge k+WIDTH.
  - sum/cout are valid from the same cycle as done.
- start while busy (SHIFT or DONE) is ignored; no queuing; the operands present then are discarded.
- Minimum spacing between accepted starts is WIDTH+2 cycles; start held high continuously restarts on each return to IDLE.
- sum/cout are not updated mid-operation; the previous result stays visible until the new completion.
- Arithmetic: unsigned modulo 2^WIDTH; {cout,sum} = a+b+cin exactly.
- cnt width is $clog2(WIDTH); it must not wrap before the terminal compare.
- rst_n low mid-operation: immediate abort, all state and outputs return to reset values, no done pulse.
- After rst_n releases: IDLE; the first start is accepted on the first clean edge.
- Inputs a/b/cin may change freely after the start edge without effect.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output ovf (1 bit), the signed two's-complement overflow, = carry into MSB XOR carry out of MSB.
  - Captured in the final SHIFT cycle alongside cout; valid with done; held like sum; reset 0.
  - The carry-into-MSB is the carry flop value in the final SHIFT cycle.
- Not defined: port and logic absent; all other behaviour identical.

Decomposition:
- Package serial_adder_pkg:
  - State enum (IDLE, SHIFT, DONE) with explicit 2-bit encoding.
  - Localparam DEFAULT_WIDTH=8.
- Sub-module fa_cell:
  - Purely combinational 1-bit full adder; inputs a, b, ci; outputs s, co.
  - The only arithmetic in the block; instantiated once.

Test Plan (WIDTH=8):
- Basic add: start with a=8'h0F, b=8'h01, cin=0 at edge k -> done high after edge k+8, sum=8'h10, cout=0, busy high for 9 cycles.
- Full carry chain: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
- Maximum sum: a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- start ignored while busy:
  - start a=8'h02, b=8'h03; pulse start with a=8'h50 on the 3rd busy cycle -> single done, sum=8'h05.
  - sum holds 8'h05 until the next completion.
- Reset mid-operation: assert rst_n=0 on the 4th SHIFT cycle -> busy/done/sum/cout go 0 immediately; after release, a=8'h10, b=8'h20 -> sum=8'h30.
- With SERIAL_ADDER_OVF_EN:
  - a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1.
  - a=8'hFF, b=8'h01 -> ovf=0, cout=1.
